counter_checker: RTL and testbench



---
 rtl/counter_checker_pkg.sv | 16 +
 rtl/counter_checker_expect.sv | 32 +++
 rtl/counter_checker.sv | 146 ++++++++++++++
 tb/tb_counter_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_checker_pkg.sv
// Shared definitions for the receive-side counter checker: the checker
// state encoding and the default widths used when the block is dropped
// into a test design without overrides.
package counter_checker_pkg;

  localparam int DEFAULT_WIDTH      = 128;
  localparam int DEFAULT_LOCK_COUNT = 4;
  localparam int DEFAULT_ERR_WIDTH  = 16;

  typedef enum logic [1:0] {
    SEED    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } checkState_t;

endpackage

// File: rtl/counter_checker_expect.sv
// Holds the previous sample and forms the wide prev+1 compare. Kept in its
// own module so the WIDTH-bit incrementer and equality tree sit apart from
// the control logic and can be timed and placed on their own.
module counter_checker_expect
  import counter_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_expected,
  output logic             o_match
);

  logic [WIDTH-1:0] r_prev;

  // Every accepted sample becomes the new reference, whatever the checker state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else if (i_load) begin
      r_prev <= i_data;
    end
  end

  // The carry out of the top bit is dropped, so all-ones is followed by zero.
  assign o_expected = r_prev + WIDTH'(1);
  assign o_match    = (i_data == o_expected);

endmodule

// File: rtl/counter_checker.sv
// Receive-side checker for the free-running test counter. It seeds on the
// first valid sample, needs LOCK_COUNT consecutive +1 steps to lock, and
// while locked counts and captures any sample that breaks the sequence.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT,
  parameter int ERR_WIDTH  = DEFAULT_ERR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [ERR_WIDTH-1:0] error_count,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_expected,
  output logic [WIDTH-1:0]     first_err_actual
);

  localparam int MC_WIDTH = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_WIDTH-1:0] LOCK_TARGET = MC_WIDTH'(LOCK_COUNT);

  checkState_t           r_state;
  checkState_t           w_nextState;
  logic [MC_WIDTH-1:0]   r_matchCount;
  logic [MC_WIDTH-1:0]   w_nextMatchCount;
  logic                  w_errorHit;
  logic                  w_load;
  logic [WIDTH-1:0]      w_expected;
  logic                  w_match;

  logic                  r_locked;
  logic                  r_errorPulse;
  logic [ERR_WIDTH-1:0]  r_errorCount;
  logic                  r_firstErrValid;
  logic [WIDTH-1:0]      r_firstErrExpected;
  logic [WIDTH-1:0]      r_firstErrActual;

  // A sample coinciding with clear is dropped entirely, including the reference update.
  assign w_load = in_valid && !clear;

  counter_checker_expect #(
    .WIDTH (WIDTH)
  ) u_expect (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_data     (in_data),
    .o_expected (w_expected),
    .o_match    (w_match)
  );

  // State and lock-progress registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= SEED;
      r_matchCount <= '0;
    end else begin
      r_state      <= w_nextState;
      r_matchCount <= w_nextMatchCount;
    end
  end

  // Sequencing: seed, count consecutive good steps up to lock, and flag a break while locked.
  always_comb begin
    w_nextState      = r_state;
    w_nextMatchCount = r_matchCount;
    w_errorHit       = 1'b0;
    if (clear) begin
      w_nextState      = SEED;
      w_nextMatchCount = '0;
    end else if (in_valid) begin
      case (r_state)
        SEED: begin
          w_nextState      = ACQUIRE;
          w_nextMatchCount = '0;
        end
        ACQUIRE: begin
          if (!w_match) begin
            w_nextMatchCount = '0;
          end else if (r_matchCount == LOCK_TARGET - 1'b1) begin
            w_nextState      = LOCKED;
            w_nextMatchCount = LOCK_TARGET;
          end else begin
            w_nextMatchCount = r_matchCount + 1'b1;
          end
        end
        LOCKED: begin
          if (!w_match) begin
            w_errorHit       = 1'b1;
            w_nextState      = ACQUIRE;
            w_nextMatchCount = '0;
          end
        end
        default: begin
          w_nextState      = SEED;
          w_nextMatchCount = '0;
        end
      endcase
    end
  end

  // Registered status: lock flag tracks the next state so it moves with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_locked     <= 1'b0;
      r_errorPulse <= 1'b0;
      r_errorCount <= '0;
    end else begin
      r_locked     <= (w_nextState == LOCKED);
      r_errorPulse <= w_errorHit;
      if (clear) begin
        r_errorCount <= '0;
      end else if (w_errorHit && (r_errorCount != '1)) begin
        r_errorCount <= r_errorCount + 1'b1;
      end
    end
  end

  // First-error capture; the data words are left alone by clear, only the valid flag drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_firstErrValid    <= 1'b0;
      r_firstErrExpected <= '0;
      r_firstErrActual   <= '0;
    end else if (clear) begin
      r_firstErrValid    <= 1'b0;
    end else if (w_errorHit && !r_firstErrValid) begin
      r_firstErrValid    <= 1'b1;
      r_firstErrExpected <= w_expected;
      r_firstErrActual   <= in_data;
    end
  end

  assign locked             = r_locked;
  assign error_pulse        = r_errorPulse;
  assign error_count        = r_errorCount;
  assign first_err_valid    = r_firstErrValid;
  assign first_err_expected = r_firstErrExpected;
  assign first_err_actual   = r_firstErrActual;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a table of {inputs, expected outputs} vectors
// covering lock, error capture, gaps, back-to-back breaks, clear and the
// 2^WIDTH wrap, followed by hand-built sequences for error-count saturation,
// clear with a coincident sample, and a mid-stream reset.
module tb_counter_checker;

  localparam int W      = 128;
  localparam int LOCKN  = 4;
  localparam int ERR_W  = 8;
  localparam int ERRMAX = (1 << ERR_W) - 1;

  typedef struct {
    logic             valid;
    logic             clr;
    logic [W-1:0]     data;
    logic             expLocked;
    logic             expPulse;
    logic [ERR_W-1:0] expCount;
    logic             expFv;
    logic             chkCap;
    logic [W-1:0]     expFe;
    logic [W-1:0]     expFa;
  } vec_t;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             clear;
  logic             locked;
  logic             error_pulse;
  logic [ERR_W-1:0] error_count;
  logic             first_err_valid;
  logic [W-1:0]     first_err_expected;
  logic [W-1:0]     first_err_actual;

  vec_t  table_q[$];
  vec_t  sb[$];
  int    checks;
  int    errors;

  counter_checker #(
    .WIDTH      (W),
    .LOCK_COUNT (LOCKN),
    .ERR_WIDTH  (ERR_W)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .clear              (clear),
    .locked             (locked),
    .error_pulse        (error_pulse),
    .error_count        (error_count),
    .first_err_valid    (first_err_valid),
    .first_err_expected (first_err_expected),
    .first_err_actual   (first_err_actual)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic v, input logic c, input logic [W-1:0] d,
                              input logic l, input logic p, input int cnt,
                              input logic fv, input logic [W-1:0] fe, input logic [W-1:0] fa);
    vec_t r;
    r.valid     = v;
    r.clr       = c;
    r.data      = d;
    r.expLocked = l;
    r.expPulse  = p;
    r.expCount  = ERR_W'(cnt);
    r.expFv     = fv;
    r.chkCap    = fv;
    r.expFe     = fe;
    r.expFa     = fa;
    return r;
  endfunction

  task automatic compare(input string name, input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (%s) actual %0h required %0h", name, tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard (%s) actual empty required entry", tag);
    end else begin
      e = sb.pop_front();
      compare("locked", tag, W'(locked), W'(e.expLocked));
      compare("error_pulse", tag, W'(error_pulse), W'(e.expPulse));
      compare("error_count", tag, W'(error_count), W'(e.expCount));
      compare("first_err_valid", tag, W'(first_err_valid), W'(e.expFv));
      if (e.chkCap) begin
        compare("first_err_expected", tag, first_err_expected, e.expFe);
        compare("first_err_actual", tag, first_err_actual, e.expFa);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    in_valid = v.valid;
    clear    = v.clr;
    in_data  = v.data;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [W-1:0] allOnes;
    logic [W-1:0] cur;
    logic [W-1:0] firstE;
    logic [W-1:0] firstA;
    vec_t         rv;
    int           cnt;

    checks   = 0;
    errors   = 0;
    allOnes  = '1;
    firstE   = '0;
    firstA   = '0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;

    // Lock from 10 and hold through a clear carrying a sample.
    table_q.push_back(mk(1, 0, 10,  0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 11,  0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 12,  0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 13,  0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 14,  1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 1, 15,  0, 0, 0, 0, 0, 0));
    // Lock at 100, break at 105, relock on 106..109.
    table_q.push_back(mk(1, 0, 96,  0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 97,  0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 98,  0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 99,  0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 100, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 101, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 105, 0, 1, 1, 1, 102, 105));
    table_q.push_back(mk(1, 0, 106, 0, 0, 1, 1, 102, 105));
    table_q.push_back(mk(1, 0, 107, 0, 0, 1, 1, 102, 105));
    table_q.push_back(mk(1, 0, 108, 0, 0, 1, 1, 102, 105));
    table_q.push_back(mk(1, 0, 109, 1, 0, 1, 1, 102, 105));
    // Gap in in_valid is not a break.
    table_q.push_back(mk(1, 0, 110, 1, 0, 1, 1, 102, 105));
    table_q.push_back(mk(1, 0, 111, 1, 0, 1, 1, 102, 105));
    table_q.push_back(mk(0, 0, 999, 1, 0, 1, 1, 102, 105));
    table_q.push_back(mk(0, 0, 999, 1, 0, 1, 1, 102, 105));
    table_q.push_back(mk(0, 0, 999, 1, 0, 1, 1, 102, 105));
    table_q.push_back(mk(1, 0, 112, 1, 0, 1, 1, 102, 105));
    // Back-to-back breaks: only the one seen while locked counts.
    table_q.push_back(mk(1, 0, 200, 0, 1, 2, 1, 102, 105));
    table_q.push_back(mk(1, 0, 300, 0, 0, 2, 1, 102, 105));
    // Clear, then lock just below the top and run through the wrap.
    table_q.push_back(mk(0, 1, 0,   0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, allOnes - 128'd5, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, allOnes - 128'd4, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, allOnes - 128'd3, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, allOnes - 128'd2, 0, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, allOnes - 128'd1, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, allOnes,          1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 1,  1, 0, 0, 0, 0, 0));
    table_q.push_back(mk(1, 0, 2,  1, 0, 0, 0, 0, 0));

    // Reset state, including the capture registers.
    repeat (2) @(posedge clk);
    #1;
    rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rv.chkCap = 1'b1;
    sb.push_back(rv);
    checkOutput("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < table_q.size(); i++) begin
      applyStimulus(table_q[i], $sformatf("vec%0d", i));
    end

    // Saturation: repeated lock then break, capture must stay on the first.
    cur = 128'd2;
    for (int e = 1; e <= ERRMAX + 4; e++) begin
      if (e == 1) begin
        firstE = cur + 128'd1;
        firstA = cur + 128'd10;
      end
      cur = cur + 128'd10;
      cnt = (e > ERRMAX) ? ERRMAX : e;
      applyStimulus(mk(1, 0, cur, 0, 1, cnt, 1, firstE, firstA), $sformatf("satBreak%0d", e));
      for (int j = 1; j <= LOCKN; j++) begin
        cur = cur + 128'd1;
        applyStimulus(mk(1, 0, cur, (j == LOCKN), 0, cnt, 1, firstE, firstA), $sformatf("satRelock%0d", e));
      end
    end

    // Clear while locked with a coincident sample, then a clean relock.
    applyStimulus(mk(1, 1, cur + 128'd1, 0, 0, 0, 0, 0, 0), "clearWithValid");
    cur = cur + 128'd2;
    applyStimulus(mk(1, 0, cur, 0, 0, 0, 0, 0, 0), "postClearSeed");
    for (int j = 1; j <= LOCKN; j++) begin
      cur = cur + 128'd1;
      applyStimulus(mk(1, 0, cur, (j == LOCKN), 0, 0, 0, 0, 0), "postClearLock");
    end

    // Break once so capture is loaded, relock, then reset asynchronously.
    applyStimulus(mk(1, 0, 128'd7000, 0, 1, 1, 1, cur + 128'd1, 128'd7000), "preResetBreak");
    for (int j = 1; j <= LOCKN; j++) begin
      applyStimulus(mk(1, 0, 128'd7000 + 128'(j), (j == LOCKN), 0, 1, 1, cur + 128'd1, 128'd7000), "preResetLock");
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rv.chkCap = 1'b1;
    sb.push_back(rv);
    checkOutput("midReset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j <= LOCKN; j++) begin
      applyStimulus(mk(1, 0, 128'd500 + 128'(j), (j == LOCKN), 0, 0, 0, 0, 0), "postResetLock");
    end

    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
